// File: rtl/fb_pkg.sv
// fb_pkg: constants and types shared by the frame-buffer port arbiter.
//   FB_IMG_W / FB_IMG_H / FB_PIXELS : default frame geometry
//   FB_ADDR_W / FB_DATA_W           : default RAM address / pixel widths
//   RD_LAT                          : read latency from accept to rd_valid
//   fb_state_e                      : frame FSM state encoding
package fb_pkg;

    localparam int FB_IMG_W  = 100;
    localparam int FB_IMG_H  = 100;
    localparam int FB_PIXELS = FB_IMG_W * FB_IMG_H;
    localparam int FB_ADDR_W = 14;
    localparam int FB_DATA_W = 8;

    // Cycles from the cycle a read is accepted to the cycle rd_valid is high.
    // The in-flight valid shift register is RD_LAT-1 stages deep.
    localparam int RD_LAT = 3;

    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_FILL     = 2'd1,
        S_DRAIN    = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: all non-clock signals of the frame-buffer arbiter.
//   pixel stream : frame_start, in_data, in_flag
//   read port    : rd_req, rd_addr, rd_ready, rd_data, rd_valid
//   RAM port     : ram_en, ram_we, ram_addr, ram_wdata, ram_rdata
//   status       : frame_done, ovf
// slave modport is the arbiter; master modport is its environment
// (pixel source, image generator and the RAM itself).
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              frame_start;
    logic [DATA_W-1:0] in_data;
    logic              in_flag;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              frame_done;
    logic              ovf;

    modport slave (
        input  frame_start, in_data, in_flag, rd_req, rd_addr, ram_rdata,
        output rd_ready, rd_data, rd_valid, ram_en, ram_we, ram_addr,
               ram_wdata, frame_done, ovf
    );

    modport master (
        output frame_start, in_data, in_flag, rd_req, rd_addr, ram_rdata,
        input  rd_ready, rd_data, rd_valid, ram_en, ram_we, ram_addr,
               ram_wdata, frame_done, ovf
    );
endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous first-word-fall-through FIFO for pending writes.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/din_i : enqueue; accepted when not full, or when full with pop_i
//   pop_i        : dequeue head (ignored when empty or flushing)
//   flush_i      : discard all contents; a push in the same cycle survives
//                  as the sole entry
//   dout_o       : current head entry
//   full_o, empty_o, count_o : occupancy
module fb_wr_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;
    logic [AW-1:0]    wr_idx;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push = push_i && (flush_i || !full_o || pop_i);
        do_pop  = pop_i && !empty_o && !flush_i;
        wr_idx  = flush_i ? '0 : wr_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= AW'(do_push);
            count_q  <= CW'(do_push);
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= din_i;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: owns the single-port frame-buffer RAM.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (slave)      : pixel stream in, read request/response, RAM port,
//                      frame_done pulse and sticky ovf
// Incoming pixels are queued with their raster address in a small write
// FIFO. Reads win the RAM port each cycle, except that after STARVE_MAX
// consecutive read grants with writes pending, one write slot is forced.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int IMG_W       = FB_IMG_W,
    parameter int IMG_H       = FB_IMG_H,
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int WFIFO_DEPTH = 16,
    parameter int STARVE_MAX  = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    fb_port_arbiter_if.slave bus
);
    localparam int PIXELS = IMG_W * IMG_H;
    localparam int ENT_W  = ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(WFIFO_DEPTH) + 1;
    localparam int SC_W   = $clog2(STARVE_MAX + 1);
    localparam int VLD_N  = RD_LAT - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    // FIFO
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ne;
    logic [ENT_W-1:0]  fifo_din, fifo_dout;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [ADDR_W-1:0] fifo_addr;
    logic [DATA_W-1:0] fifo_data;

    // Arbitration
    logic              rd_ready, rd_gnt, wr_gnt;
    logic [SC_W-1:0]   starve_q, starve_d;

    // Frame FSM
    fb_state_e         state_q;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_next, push_addr;
    logic              push_req, drop, last_px, last_wr;
    logic              ovf_q, frame_done_q;

    // RAM port and read pipeline
    logic              ram_en_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [VLD_N-1:0]  vld_pipe_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    fb_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .flush_i (bus.frame_start),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign fifo_addr = fifo_dout[ENT_W-1:DATA_W];
    assign fifo_data = fifo_dout[DATA_W-1:0];

    always_comb begin
        fifo_ne  = !fifo_empty;
        rd_ready = !(fifo_ne && starve_q == SC_W'(STARVE_MAX));
        rd_gnt   = bus.rd_req && rd_ready;
        // A frame_start flushes the queue, so the old head must not be
        // issued in that same cycle.
        wr_gnt   = fifo_ne && !rd_gnt && !bus.frame_start;
        fifo_pop = wr_gnt;

        // frame_start restarts the raster, so a pixel arriving with it is
        // pixel 0 regardless of the current state.
        push_req  = bus.in_flag && (bus.frame_start || state_q == S_FILL);
        push_addr = bus.frame_start ? '0 : wr_cnt_q;
        fifo_din  = {push_addr, bus.in_data};
        fifo_push = push_req && (bus.frame_start || !fifo_full || fifo_pop);
        drop      = push_req && !fifo_push;
        last_px   = push_req && (push_addr == LAST_ADDR);
        // Dropped pixels still advance the counter to keep raster geometry.
        wr_cnt_next = last_px ? '0 : push_addr + ADDR_W'(1);
        last_wr   = wr_gnt && (fifo_cnt == CNT_W'(1));

        starve_d = starve_q;
        if (rd_gnt && fifo_ne)
            starve_d = (starve_q == SC_W'(STARVE_MAX)) ? starve_q : starve_q + SC_W'(1);
        else if (wr_gnt || !fifo_ne)
            starve_d = '0;

        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (rd_gnt) begin
            ram_addr_d = bus.rd_addr;
        end else if (wr_gnt) begin
            ram_addr_d  = fifo_addr;
            ram_wdata_d = fifo_data;
        end
    end

    // Frame FSM with registered frame_done / ovf.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_WAIT_SOF;
            wr_cnt_q     <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (bus.frame_start) begin
                // Aborting a frame: no frame_done, fresh ovf.
                ovf_q    <= 1'b0;
                wr_cnt_q <= bus.in_flag ? wr_cnt_next : '0;
                state_q  <= last_px ? S_DRAIN : S_FILL;
            end else begin
                case (state_q)
                    S_FILL: begin
                        if (bus.in_flag) begin
                            wr_cnt_q <= wr_cnt_next;
                            if (drop)    ovf_q   <= 1'b1;
                            if (last_px) state_q <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (last_wr || fifo_empty) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_WAIT_SOF;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM port registers, starvation counter and read return pipeline.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            starve_q    <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            vld_pipe_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            ram_en_q    <= rd_gnt || wr_gnt;
            ram_we_q    <= wr_gnt;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            // Stage 0: address on the RAM; last stage: ram_rdata valid.
            vld_pipe_q  <= {vld_pipe_q[VLD_N-2:0], rd_gnt};
            rd_valid_q  <= vld_pipe_q[VLD_N-1];
            if (vld_pipe_q[VLD_N-1]) rd_data_q <= bus.ram_rdata;
        end
    end

    assign bus.rd_ready   = rd_ready;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.frame_done = frame_done_q;
    assign bus.ovf        = ovf_q;

endmodule
